seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter that drives the single-bit input of the overlapping "101"/"110" Moore sequence detectors. It loads a parallel word through a ready/load handshake and shifts it out MSB-first, one bit per clock, with a valid qualifier. An optional built-in reference model counts the "101" and "110" occurrences it has put on the line, so a bench can check the detector's hit count without a separate scoreboard.

## Interface
- WIDTH, 16: bits per loaded word; must be at least 2.
- CNT_W, 8: width of the expected-hit counter.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  request to accept `data`; only takes effect while `ready`=1
- data  input  WIDTH  word to transmit; bit WIDTH-1 is sent first
- ready  output  1  block is idle and can accept a word
- out  output  1  serial bit line; connects to the detector's `in`
- out_valid  output  1  `out` carries a payload bit
- done  output  1  one-cycle pulse after the last bit
- exp_cnt  output  CNT_W  expected overlapping "101" plus "110" hits seen on `out`

## Operation
- State machine: IDLE, SHIFT, DONE. Reset state is IDLE.
- All outputs are registered. Reset values:
  - `ready`=1
  - `out`=0, `out_valid`=0, `done`=0, `exp_cnt`=0
  - shift register=0, bit counter=0
- IDLE:
  - `ready`=1.
  - When `load`=1 at a clock edge: capture `data` into the shift register, set bit counter to WIDTH-1, go to SHIFT.
  - Otherwise stay in IDLE with `out`=0.
- SHIFT:
  - `out` = shift register MSB; `out_valid`=1; `ready`=0.
  - At each edge the register shifts left with zero fill and the counter decrements.
  - When the counter is 0 at an edge, go to DONE.
  - `load` is ignored during SHIFT.
- DONE:
  - `done`=1, `out`=0, `out_valid`=0, `ready`=0.
  - Next edge goes to IDLE.
- The line idles at 0 outside SHIFT. The detector therefore sees zeros between words.
- Reference model (present only when the macro below is defined):
  - 3-bit history register `hist`, reset to 000.
  - At every edge, in all states, `hist` <= {hist[1:0], out}.
  - If the new `hist` equals 101 or 110, `exp_cnt` increments, saturating at 2^CNT_W-1.
  - Matches overlap.
  - `hist` and `exp_cnt` are cleared only by `rst`. They persist across words, so patterns that straddle a word boundary or idle zeros are counted.
  - Because `hist` resets to 000, the first two bits after reset cannot produce a false match.

## Timing
- `load` sampled at edge k:
  - Bit i (i=0..WIDTH-1, MSB first) is on `out` with `out_valid`=1 during the cycle after edge k+i.
  - After edge k+WIDTH: `done`=1, `out_valid`=0.
  - After edge k+WIDTH+1: `ready`=1.
  - The earliest next `load` is sampled at edge k+WIDTH+2. This gives a 2-cycle zero gap between back-to-back words.
- `exp_cnt` reflects a window one edge after the window's third bit leaves `out`. Count all bits of a word, plus one trailing zero, at edge k+WIDTH+1.
- `rst` asserted at any time forces all outputs and state to their reset values immediately, without waiting for a clock edge. A word in flight is discarded. Operation resumes in IDLE on the first edge after `rst` deasserts.

## Configuration
- SEQ_TX_EXPCNT_EN defined:
  - `hist` and the saturating `exp_cnt` model are built as described above.
- SEQ_TX_EXPCNT_EN undefined:
  - No history or counter logic is built.
  - `exp_cnt` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Word 16'hB000 loaded after reset:
  - `out` sequence is 1,0,1,1,0, then eleven 0s, `out_valid` high for exactly 16 cycles.
  - `done` pulses once, then `ready` rises.
  - `exp_cnt`=2.
- Word 16'hAAAA after reset → `exp_cnt`=7. Then word 16'hFFFF → `exp_cnt`=8 (the trailing 0 forms one "110").
- Back-to-back words 16'h0001 then 16'h8000, with `load` held high:
  - The second word's first bit appears exactly WIDTH+2 cycles after the first word's first bit.
  - Pattern "1,0,0,1" across the gap gives no hit; `exp_cnt`=0.
- `load` pulsed with `data`=16'hFFFF during SHIFT of 16'h0000: ignored; `out` stays 0 for all 16 bits.
- `rst` asserted at bit 5 of 16'hB000:
  - `out`=0, `out_valid`=0, `ready`=1, `exp_cnt`=0 with no clock edge required.
  - After `rst` deasserts, a new load of 16'hB000 gives `exp_cnt`=2.
- Saturation, CNT_W=8, macro defined: 37 loads of 16'hAAAA → `exp_cnt`=255 and holds. With the macro undefined, `exp_cnt`=0 throughout.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a word on ready/load and shifts it out MSB-first with a valid qualifier.
// Define SEQ_TX_EXPCNT_EN to build the overlapping "101"/"110" expected-hit counter on exp_cnt.
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done,
  output logic [CNT_W-1:0] exp_cnt
);

  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bcnt;

  // out is registered, so sreg holds the bits still waiting behind the one on the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bcnt      <= '0;
      ready     <= 1'b1;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            sreg      <= {data[WIDTH-2:0], 1'b0};
            bcnt      <= BW'(WIDTH - 1);
            out       <= data[WIDTH-1];
            out_valid <= 1'b1;
            ready     <= 1'b0;
            state     <= SHIFT;
          end else begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            ready     <= 1'b1;
          end
        end
        SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          if (bcnt == '0) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            bcnt <= bcnt - 1'b1;
            out  <= sreg[WIDTH-1];
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
          ready     <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEQ_TX_EXPCNT_EN
  // Only the two older history bits are stored; the newest bit of the window is out itself.
  logic [1:0]       hist;
  logic [2:0]       window;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    window = {hist, out};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      cnt  <= '0;
    end else begin
      hist <= window[1:0];
      if ((window == 3'b101 || window == 3'b110) && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign exp_cnt = cnt;
`else
  assign exp_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table of words with hand-derived hit counts, corner-case sequences,
// and randomized words checked against a stream-level window-counting model.
module tb_seq_pattern_tx;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned MAXC  = (1 << CNT_W) - 1;
`ifdef SEQ_TX_EXPCNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             done;
  logic [CNT_W-1:0] exp_cnt;

  int unsigned total;
  int unsigned bad;

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .ready(ready),
    .out(out), .out_valid(out_valid), .done(done), .exp_cnt(exp_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int unsigned expect_cnt(input int unsigned hits);
    if (!EN) return 0;
    return (hits > MAXC) ? MAXC : hits;
  endfunction

  // Reference model: every bit present on the line at a clock edge is appended to a stream,
  // and each 3-bit window ending in the new bit that reads 101 or 110 is a hit.
  bit          line[$];
  int unsigned mcount;

  always @(posedge rst) begin
    line.delete();
    mcount = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      line.delete();
      mcount = 0;
    end else begin
      chk("exp_cnt_vs_model", 32'(exp_cnt), expect_cnt(mcount));
      line.push_back(out);
      if (line.size() > 3) void'(line.pop_front());
      if (line.size() == 3 && line[0] && (line[1] != line[2]) && mcount < MAXC) mcount++;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_out"}, 32'(out), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_exp_cnt"}, 32'(exp_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_ready();
    int unsigned k = 0;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 1);
  endtask

  // Sends one word and checks every bit, the done pulse and the return of ready.
  task automatic send(input logic [WIDTH-1:0] w, input bit noise);
    int unsigned vcount = 0;
    wait_ready();
    load = 1'b1;
    data = w;
    for (int i = 0; i < int'(WIDTH); i++) begin
      @(negedge clk);
      if (i == 0) load = 1'b0;
      chk($sformatf("bit%0d_out", i), 32'(out), 32'(w[WIDTH-1-i]));
      chk("shift_ready", 32'(ready), 0);
      if (out_valid && !done) vcount++;
      if (noise && i == 5) begin
        load = 1'b1;
        data = '1;
      end else if (noise && i == 6) begin
        load = 1'b0;
      end
    end
    chk("valid_cycles", vcount, WIDTH);
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_out_valid", 32'(out_valid), 0);
    chk("done_out", 32'(out), 0);
    chk("done_ready", 32'(ready), 0);
    @(negedge clk);
    chk("after_done_ready", 32'(ready), 1);
    chk("after_done_done", 32'(done), 0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] word;
    int unsigned      hits;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0, p1;
    bit prev;
    total = 0;
    bad = 0;
    rst = 1'b1;
    load = 1'b0;
    data = '0;
    #1 check_reset_vals("por");
    @(negedge clk);
    #2 rst = 1'b0;

    vecs[0] = '{16'hB000, 2};
    vecs[1] = '{16'hAAAA, 7};
    vecs[2] = '{16'h0000, 0};
    vecs[3] = '{16'hFFFF, 1};
    vecs[4] = '{16'h8000, 0};
    vecs[5] = '{16'hD000, 2};
    vecs[6] = '{16'h5000, 1};
    vecs[7] = '{16'h6DB6, 9};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(vecs[i].word, 1'b0);
      chk($sformatf("table%0d_exp_cnt", i), 32'(exp_cnt), expect_cnt(vecs[i].hits));
    end

    // AAAA then FFFF accumulate: the trailing zero after FFFF forms one 110.
    do_reset();
    send(16'hAAAA, 1'b0);
    send(16'hFFFF, 1'b0);
    chk("aaaa_ffff_exp_cnt", 32'(exp_cnt), expect_cnt(8));

    // Back-to-back with load held high.
    do_reset();
    wait_ready();
    load = 1'b1;
    data = 16'h0001;
    p0 = -1;
    p1 = -1;
    prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) data = 16'h8000;
      if (out_valid && !prev) begin
        if (p0 < 0) p0 = c;
        else if (p1 < 0) begin
          p1 = c;
          load = 1'b0;
          chk("b2b_second_first_bit", 32'(out), 1);
        end
      end
      prev = out_valid;
    end
    load = 1'b0;
    chk("b2b_first_start", 32'(p0), 0);
    chk("b2b_gap", 32'(p1 - p0), WIDTH + 2);
    chk("b2b_exp_cnt", 32'(exp_cnt), 0);

    // load during SHIFT is ignored.
    do_reset();
    send(16'h0000, 1'b1);
    chk("noise_exp_cnt", 32'(exp_cnt), 0);

    // Asynchronous reset mid-word.
    do_reset();
    wait_ready();
    load = 1'b1;
    data = 16'hB000;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i == 0) load = 1'b0;
    end
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    send(16'hB000, 1'b0);
    chk("post_rst_exp_cnt", 32'(exp_cnt), expect_cnt(2));

    // Saturation.
    do_reset();
    for (int i = 0; i < 37; i++) send(16'hAAAA, 1'b0);
    chk("sat_exp_cnt", 32'(exp_cnt), expect_cnt(37 * 7));
    send(16'hB000, 1'b0);
    chk("sat_hold", 32'(exp_cnt), expect_cnt(37 * 7 + 2));

    // Randomized words with random idle gaps and occasional resets.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int unsigned gap;
      if ($urandom_range(19, 0) == 0) do_reset();
      send(WIDTH'($urandom), 1'b0);
      gap = $urandom_range(3, 0);
      for (int g = 0; g < int'(gap); g++) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
